// File: rtl/hazard3_ahb_sram_pkg.sv
// rtl/hazard3_ahb_sram_pkg.sv - AHB transfer codes, error FSM states and byte-lane helpers
package hazard3_ahb_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HWORD = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;

    typedef enum logic [1:0] {
        ERR_IDLE,
        ERR_CYC1,
        ERR_CYC2
    } err_state_t;

    // Little-endian byte lanes touched by a transfer of the given size and offset
    function automatic logic [3:0] ahb_byte_mask(input logic [2:0] hsize, input logic [1:0] addr);
        case (hsize)
            HSIZE_BYTE:  return 4'b0001 << addr;
            HSIZE_HWORD: return addr[1] ? 4'b1100 : 4'b0011;
            default:     return 4'b1111;
        endcase
    endfunction

    // Oversized or misaligned transfers are answered with an ERROR response
    function automatic logic ahb_xfer_err(input logic [2:0] hsize, input logic [1:0] addr);
        return (hsize > HSIZE_WORD) ||
               (hsize == HSIZE_HWORD && addr[0]) ||
               (hsize == HSIZE_WORD && addr != 2'b00);
    endfunction

endpackage

// File: rtl/hazard3_ahb_sram_if.sv
// rtl/hazard3_ahb_sram_if.sv - AHB5 subordinate-side bus signals with master/slave views
interface hazard3_ahb_sram_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic              hsel;
    logic              hready;
    logic [W_ADDR-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [7:0]        hmaster;
    logic              hexcl;
    logic [W_DATA-1:0] hwdata;
    logic              hreadyout;
    logic              hresp;
    logic              hexokay;
    logic [W_DATA-1:0] hrdata;

    modport master (
        output hsel, hready, haddr, htrans, hwrite, hsize, hmaster, hexcl, hwdata,
        input  hreadyout, hresp, hexokay, hrdata
    );

    modport slave (
        input  hsel, hready, haddr, htrans, hwrite, hsize, hmaster, hexcl, hwdata,
        output hreadyout, hresp, hexokay, hrdata
    );
endinterface

// File: rtl/hazard3_ahb_excl_monitor.sv
// rtl/hazard3_ahb_excl_monitor.sv - single-reservation exclusive monitor for LR/SC and AMO sequences
module hazard3_ahb_excl_monitor
    import hazard3_ahb_sram_pkg::*;
#(
    parameter int W_SADDR = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_aph_ok,
    input  logic               i_write,
    input  logic               i_excl,
    input  logic [7:0]         i_master,
    input  logic [W_SADDR-1:0] i_addr,
    output logic               o_excl_pass
);
    logic               r_valid;
    logic [7:0]         r_master;
    logic [W_SADDR-1:0] r_addr;
    logic               w_wr_performed;

    assign o_excl_pass    = r_valid && (r_master == i_master) && (r_addr == i_addr);
    assign w_wr_performed = i_aph_ok && i_write && (!i_excl || o_excl_pass);

    // Exclusive reads claim the reservation; any performed write to the reserved word drops it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_master <= 8'h00;
            r_addr   <= '0;
        end else if (i_aph_ok && !i_write && i_excl) begin
            r_valid  <= 1'b1;
            r_master <= i_master;
            r_addr   <= i_addr;
        end else if (w_wr_performed && (r_addr == i_addr)) begin
            r_valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/hazard3_ahb_sram.sv
// rtl/hazard3_ahb_sram.sv - zero-wait AHB5 SRAM subordinate with write buffer; HAZARD3_SRAM_EXCL_MONITOR_EN adds exclusive monitor
module hazard3_ahb_sram
    import hazard3_ahb_sram_pkg::*;
#(
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32,
    parameter int DEPTH   = 4096,
    localparam int W_SADDR = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard3_ahb_sram_if.slave   ahb,
    output logic [W_SADDR-1:0]  sram_addr,
    output logic                sram_cs,
    output logic                sram_we,
    output logic [3:0]          sram_wbmask,
    output logic [W_DATA-1:0]   sram_wdata,
    input  logic [W_DATA-1:0]   sram_rdata
);
    // Address phase decode
    logic               w_aph;
    logic               w_aph_err;
    logic               w_aph_ok;
    logic               w_rd_aph;
    logic               w_wr_aph;
    logic               w_wr_perform;
    logic               w_excl_pass;
    logic [W_SADDR-1:0] w_aph_addr;
    logic [3:0]         w_aph_mask;
    logic               w_unused;

    assign w_aph      = ahb.hsel && ahb.htrans[1] && ahb.hready;
    assign w_aph_err  = ahb_xfer_err(ahb.hsize, ahb.haddr[1:0]);
    assign w_aph_ok   = w_aph && !w_aph_err;
    assign w_rd_aph   = w_aph_ok && !ahb.hwrite;
    assign w_wr_aph   = w_aph_ok && ahb.hwrite;
    assign w_aph_addr = ahb.haddr[W_SADDR+1:2];
    assign w_aph_mask = ahb_byte_mask(ahb.hsize, ahb.haddr[1:0]);
    assign w_unused   = ^{ahb.haddr[W_ADDR-1:W_SADDR+2], ahb.htrans[0], ahb.hmaster};

`ifdef HAZARD3_SRAM_EXCL_MONITOR_EN
    hazard3_ahb_excl_monitor #(.W_SADDR(W_SADDR)) u_excl_monitor (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_aph_ok    (w_aph_ok),
        .i_write     (ahb.hwrite),
        .i_excl      (ahb.hexcl),
        .i_master    (ahb.hmaster),
        .i_addr      (w_aph_addr),
        .o_excl_pass (w_excl_pass)
    );
    assign w_wr_perform = w_wr_aph && (!ahb.hexcl || w_excl_pass);
`else
    assign w_excl_pass  = 1'b0;
    assign w_wr_perform = w_wr_aph && !ahb.hexcl;
`endif

    // Data phase state; an OKAY data phase always lasts exactly one cycle
    logic               r_dph_read;
    logic               r_dph_write;
    logic               r_hexokay;
    logic [W_SADDR-1:0] r_dph_addr;
    logic [3:0]         r_dph_mask;

    // Capture the accepted address phase for use in the following data phase
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dph_read  <= 1'b0;
            r_dph_write <= 1'b0;
            r_hexokay   <= 1'b0;
            r_dph_addr  <= '0;
            r_dph_mask  <= 4'h0;
        end else begin
            r_dph_read  <= w_rd_aph;
            r_dph_write <= w_wr_perform;
            r_hexokay   <= w_wr_perform && ahb.hexcl && w_excl_pass;
            if (w_aph_ok) begin
                r_dph_addr <= w_aph_addr;
                r_dph_mask <= w_aph_mask;
            end
        end
    end

    // One-entry write buffer: a write dph can only collide with a read aph once in a row,
    // because the cycle carrying its own aph had no read and so drained any older entry
    logic               r_wb_valid;
    logic [W_SADDR-1:0] r_wb_addr;
    logic [3:0]         r_wb_mask;
    logic [W_DATA-1:0]  r_wb_data;
    logic               w_wb_load;
    logic               w_wb_commit;

    assign w_wb_commit = r_wb_valid && !w_rd_aph;
    assign w_wb_load   = r_dph_write && (w_rd_aph || r_wb_valid);

    // Park a write that lost the SRAM port; drain it on the first free cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_mask  <= 4'h0;
            r_wb_data  <= '0;
        end else if (w_wb_load) begin
            r_wb_valid <= 1'b1;
            r_wb_addr  <= r_dph_addr;
            r_wb_mask  <= r_dph_mask;
            r_wb_data  <= ahb.hwdata;
        end else if (w_wb_commit) begin
            r_wb_valid <= 1'b0;
        end
    end

    // SRAM port arbitration: read aph, then buffer commit, then direct dph write
    always_comb begin
        sram_cs     = 1'b0;
        sram_we     = 1'b0;
        sram_addr   = w_aph_addr;
        sram_wbmask = 4'h0;
        sram_wdata  = ahb.hwdata;
        if (w_rd_aph) begin
            sram_cs     = 1'b1;
        end else if (r_wb_valid) begin
            sram_cs     = 1'b1;
            sram_we     = 1'b1;
            sram_addr   = r_wb_addr;
            sram_wbmask = r_wb_mask;
            sram_wdata  = r_wb_data;
        end else if (r_dph_write) begin
            sram_cs     = 1'b1;
            sram_we     = 1'b1;
            sram_addr   = r_dph_addr;
            sram_wbmask = r_dph_mask;
        end
        if (!rst_n) begin
            sram_cs = 1'b0;
            sram_we = 1'b0;
        end
    end

    // Read data with not-yet-committed buffered bytes merged over the SRAM word
    logic [W_DATA-1:0] w_rdata;
    always_comb begin
        w_rdata = sram_rdata;
        for (int b = 0; b < 4; b++) begin
            if (r_wb_valid && (r_wb_addr == r_dph_addr) && r_wb_mask[b])
                w_rdata[8*b +: 8] = r_wb_data[8*b +: 8];
        end
    end

    assign ahb.hrdata  = r_dph_read ? w_rdata : '0;
    assign ahb.hexokay = r_hexokay;

    // Two-cycle ERROR response sequencer
    err_state_t r_err_state;
    err_state_t w_err_next;
    logic       w_hreadyout;
    logic       w_hresp;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_err_state <= ERR_IDLE;
        else        r_err_state <= w_err_next;
    end

    // Next state: an errored aph starts the sequence; cycle 2 can accept a new errored aph
    always_comb begin
        w_err_next = r_err_state;
        case (r_err_state)
            ERR_CYC1: w_err_next = ERR_CYC2;
            default:  w_err_next = (w_aph && w_aph_err) ? ERR_CYC1 : ERR_IDLE;
        endcase
    end

    // Response outputs per state
    always_comb begin
        w_hreadyout = 1'b1;
        w_hresp     = 1'b0;
        case (r_err_state)
            ERR_CYC1: begin
                w_hreadyout = 1'b0;
                w_hresp     = 1'b1;
            end
            ERR_CYC2: w_hresp = 1'b1;
            default: ;
        endcase
    end

    assign ahb.hreadyout = w_hreadyout;
    assign ahb.hresp     = w_hresp;

endmodule
